// File: rtl/spi_accel_pkg.sv
// Shared types and register-map constants for the SPI accelerometer responder.
package spi_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] CMD_WRITE  = 8'h0A;

    localparam logic [5:0] XDATA      = 6'h08;
    localparam logic [5:0] YDATA      = 6'h09;
    localparam logic [5:0] ZDATA      = 6'h0A;
    localparam logic [5:0] STATUS     = 6'h0B;
    localparam logic [5:0] POWER_CTL  = 6'h2D;
    localparam logic [5:0] SCRATCH_LO = 6'h20;
    localparam logic [5:0] SCRATCH_HI = 6'h2E;

    localparam int N_SCRATCH = 15;
    localparam int PWR_IDX   = int'(POWER_CTL - SCRATCH_LO);

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes sclk/cs_n/mosi into clk and flags sclk rise/fall and cs_n fall/rise.
// Edge pulses appear SYNC_STAGES clk after the pin edge; mosi_s stays aligned with sclk.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_n_s,
    output logic mosi_s
);
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    // cs_n chain resets to the deselected level so no false fall fires out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating the accelerometer register file: cmd byte, addr byte, auto-incrementing data.
// Pins are oversampled in clk (SCLK <= clk/8); MOSI taken on detected rise, MISO updated on detected fall.
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [7:0] z_in,
    input  logic       sample_valid,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] power_ctl,
    output logic       busy
);
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk      (clk),
        .rst_n    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] tx_q, tx_d;
    logic [5:0] addr_q, addr_d;
    logic       miso_q, miso_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
    logic [7:0] pdx_q, pdx_d, pdy_q, pdy_d, pdz_q, pdz_d;
    logic       pend_q, pend_d;
    logic       dr_q, dr_d;
    logic [7:0] scratch_q [N_SCRATCH];
    logic [7:0] scratch_d [N_SCRATCH];

    logic [7:0] byte_in, rd_data;
    logic [5:0] rd_addr;
    logic [3:0] sidx;
    logic       byte_done, clr_dr, set_dr, busy_w;

    assign busy_w    = ~cs_n_s;
    assign byte_in   = {shift_q[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) && !cs_rise;
    assign rd_addr   = (state_q == ST_ADDR) ? byte_in[5:0] : addr_q + 6'd1;
    assign sidx      = 4'(addr_q - SCRATCH_LO);

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr >= SCRATCH_LO && rd_addr <= SCRATCH_HI) begin
            rd_data = scratch_q[4'(rd_addr - SCRATCH_LO)];
        end else begin
            case (rd_addr)
                6'h00:   rd_data = DEVID_AD;
                6'h01:   rd_data = DEVID_MST;
                6'h02:   rd_data = PARTID;
                XDATA:   rd_data = shx_q;
                YDATA:   rd_data = shy_q;
                ZDATA:   rd_data = shz_q;
                STATUS:  rd_data = {7'b0, dr_q};
                default: rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        scratch_d   = scratch_q;
        clr_dr      = 1'b0;
        if (sclk_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: if (byte_done) begin
                cmd_d   = byte_in;
                state_d = ST_ADDR;
            end
            ST_ADDR: if (byte_done) begin
                addr_d = byte_in[5:0];
                if (cmd_q == CMD_READ) begin
                    state_d = ST_RD;
                    tx_d    = rd_data;
                end else if (cmd_q == CMD_WRITE) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_IGNORE;
                end
            end
            ST_RD: begin
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                // Z is cleared once fully shifted out, so a STATUS byte loaded alongside still shows the sample
                if (byte_done) begin
                    addr_d = addr_q + 6'd1;
                    tx_d   = rd_data;
                    clr_dr = (addr_q == ZDATA);
                end
            end
            ST_WR: if (byte_done) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = byte_in;
                if (addr_q >= SCRATCH_LO && addr_q <= SCRATCH_HI) scratch_d[sidx] = byte_in;
                addr_d = addr_q + 6'd1;
            end
            default: ;
        endcase
        if (state_q != ST_RD) miso_d = 1'b0;
        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end
    end

    // Captures during a burst are parked and applied once cs_n is seen high again
    always_comb begin
        shx_d  = shx_q;
        shy_d  = shy_q;
        shz_d  = shz_q;
        pdx_d  = pdx_q;
        pdy_d  = pdy_q;
        pdz_d  = pdz_q;
        pend_d = pend_q;
        set_dr = 1'b0;
        if (pend_q && !busy_w) begin
            shx_d  = pdx_q;
            shy_d  = pdy_q;
            shz_d  = pdz_q;
            pend_d = 1'b0;
            set_dr = 1'b1;
        end
        if (sample_valid) begin
            if (busy_w) begin
                pend_d = 1'b1;
                pdx_d  = x_in;
                pdy_d  = y_in;
                pdz_d  = z_in;
            end else begin
                shx_d  = x_in;
                shy_d  = y_in;
                shz_d  = z_in;
                set_dr = 1'b1;
            end
        end
        dr_d = dr_q;
        if (clr_dr) dr_d = 1'b0;
        if (set_dr) dr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            cmd_q       <= 8'h00;
            addr_q      <= 6'd0;
            tx_q        <= 8'h00;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'h00;
            shx_q       <= 8'h00;
            shy_q       <= 8'h00;
            shz_q       <= 8'h00;
            pdx_q       <= 8'h00;
            pdy_q       <= 8'h00;
            pdz_q       <= 8'h00;
            pend_q      <= 1'b0;
            dr_q        <= 1'b0;
            for (int i = 0; i < N_SCRATCH; i++) scratch_q[i] <= 8'h00;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            shx_q       <= shx_d;
            shy_q       <= shy_d;
            shz_q       <= shz_d;
            pdx_q       <= pdx_d;
            pdy_q       <= pdy_d;
            pdz_q       <= pdz_d;
            pend_q      <= pend_d;
            dr_q        <= dr_d;
            scratch_q   <= scratch_d;
        end
    end

    assign miso      = miso_q & ~cs_n;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign power_ctl = scratch_q[PWR_IDX];
    assign busy      = busy_w;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Self-checking bench: fixed burst table, hand-written corner sequences, then random bursts vs a register-map model.
module tb_spi_accel_responder;
    localparam int HALF = 5;

    logic       clk = 1'b0, reset = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, sample_valid = 1'b0;
    logic [7:0] x_in = 8'h00, y_in = 8'h00, z_in = 8'h00;
    logic       miso, wr_strobe, busy;
    logic [5:0] wr_addr;
    logic [7:0] wr_data, power_ctl;

    always #5 clk = ~clk;

    spi_accel_responder dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .sample_valid(sample_valid),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .power_ctl(power_ctl), .busy(busy)
    );

    int n_cmp = 0, n_err = 0;
    int strobe_cnt = 0;
    logic [5:0] mon_addr = 6'd0;
    logic [7:0] mon_data = 8'h00;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            mon_addr   = wr_addr;
            mon_data   = wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: register map as plain arrays ----------------
    logic [7:0] m_scr [64];
    logic [7:0] m_x, m_y, m_z, p_x, p_y, p_z;
    bit         m_dr, m_pend;
    int         m_strobes = 0;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_scr[i] = 8'h00;
        m_x = 0; m_y = 0; m_z = 0; m_dr = 0; m_pend = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return 8'hAD;
        if (a == 6'h01) return 8'h1D;
        if (a == 6'h02) return 8'hF2;
        if (a == 6'h08) return m_x;
        if (a == 6'h09) return m_y;
        if (a == 6'h0A) return m_z;
        if (a == 6'h0B) return {7'b0, m_dr};
        if (a >= 6'h20 && a <= 6'h2E) return m_scr[a];
        return 8'h00;
    endfunction

    task automatic model_cs_rise();
        if (m_pend) begin
            m_x = p_x; m_y = p_y; m_z = p_z; m_dr = 1; m_pend = 0;
        end
    endtask

    // ---------------- pin-level drivers ----------------
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic pulse_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        @(negedge clk);
        x_in = x; y_in = y; z_in = z; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (cs_n) begin
            m_x = x; m_y = y; m_z = z; m_dr = 1;
        end else begin
            p_x = x; p_y = y; p_z = z; m_pend = 1;
        end
    endtask

    // Full burst; returns what MISO gave and what the model expects for each data byte.
    task automatic burst(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                         input logic [31:0] txd, output logic [31:0] rxd, output logic [31:0] expd);
        logic [7:0] r;
        logic [5:0] a;
        bit         clr_next;
        a = addr[5:0]; clr_next = 0; rxd = '0; expd = '0;
        cs_low();
        spi_bits(cmd, 8, r);
        check("cmd byte miso", r, 0);
        spi_bits(addr, 8, r);
        check("addr byte miso", r, 0);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d, e;
            d = txd[31-8*i -: 8];
            e = 8'h00;
            if (cmd == 8'h0B) begin
                e = m_read(a);
                if (clr_next) m_dr = 0;
                clr_next = (a == 6'h0A);
            end else if (cmd == 8'h0A) begin
                m_strobes++;
                if (a >= 6'h20 && a <= 6'h2E) m_scr[a] = d;
            end
            spi_bits(d, 8, r);
            rxd[31-8*i -: 8]  = r;
            expd[31-8*i -: 8] = e;
            a = a + 6'd1;
        end
        if (clr_next) m_dr = 0;
        cs_high();
        model_cs_rise();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        logic [31:0] tx;
        logic [31:0] exp;
        logic [7:0]  pwr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] rxd, expd;
        logic [7:0]  r, cmd, addr;
        logic [5:0]  last_a;
        logic [7:0]  last_d;
        int          n;

        vecs[0] = '{8'h0B, 8'h08, 4, 32'h0,          32'h12345601, 8'h00};
        vecs[1] = '{8'h0B, 8'h0B, 1, 32'h0,          32'h00000000, 8'h00};
        vecs[2] = '{8'h0B, 8'h00, 3, 32'h0,          32'hAD1DF200, 8'h00};
        vecs[3] = '{8'h0A, 8'h2D, 1, 32'h02000000,   32'h00000000, 8'h02};
        vecs[4] = '{8'h0B, 8'h2D, 1, 32'h0,          32'h02000000, 8'h02};
        vecs[5] = '{8'h0B, 8'h3F, 2, 32'h0,          32'h00AD0000, 8'h02};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset miso", miso, 0);
        check("reset wr_strobe", wr_strobe, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset power_ctl", power_ctl, 0);
        check("reset busy", busy, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // ---- table-driven bursts ----
        pulse_sample(8'h12, 8'h34, 8'h56);
        repeat (4) @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            burst(vecs[t].cmd, vecs[t].addr, vecs[t].n, vecs[t].tx, rxd, expd);
            for (int i = 0; i < vecs[t].n; i++)
                check($sformatf("vec%0d byte%0d", t, i), rxd[31-8*i -: 8], vecs[t].exp[31-8*i -: 8]);
            check($sformatf("vec%0d power_ctl", t), power_ctl, vecs[t].pwr);
        end
        check("table strobe count", strobe_cnt, 1);
        check("table wr_addr", mon_addr, 6'h2D);
        check("table wr_data", mon_data, 8'h02);

        // ---- capture during a burst stays pending ----
        pulse_sample(8'h12, 8'h34, 8'h56);
        cs_low();
        check("busy in burst", busy, 1);
        spi_bits(8'h0B, 8, r);
        pulse_sample(8'h77, 8'h88, 8'h99);
        spi_bits(8'h08, 8, r);
        spi_bits(8'h00, 8, r); check("coherent x", r, 8'h12);
        spi_bits(8'h00, 8, r); check("coherent y", r, 8'h34);
        spi_bits(8'h00, 8, r); check("coherent z", r, 8'h56);
        cs_high();
        m_dr = 0;
        model_cs_rise();
        check("busy after burst", busy, 0);
        burst(8'h0B, 8'h08, 2, 32'h0, rxd, expd);
        check("pending x applied", rxd[31:24], 8'h77);
        check("pending y applied", rxd[23:16], 8'h88);

        // ---- asynchronous reset after 12 SCLKs of a read ----
        cs_low();
        spi_bits(8'h0B, 8, r);
        spi_bits(8'h08, 4, r);
        reset = 1'b0;
        #1;
        check("midburst rst miso", miso, 0);
        check("midburst rst wr_strobe", wr_strobe, 0);
        check("midburst rst wr_addr", wr_addr, 0);
        check("midburst rst wr_data", wr_data, 0);
        check("midburst rst power_ctl", power_ctl, 0);
        check("midburst rst busy", busy, 0);
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        burst(8'h0B, 8'h00, 3, 32'h0, rxd, expd);
        check("post-reset ids", rxd[31:8], 24'hAD1DF2);
        burst(8'h0B, 8'h08, 4, 32'h0, rxd, expd);
        check("post-reset shadow", rxd, expd);

        // ---- write aborted after 4 data bits ----
        n = strobe_cnt;
        cs_low();
        spi_bits(8'h0A, 8, r);
        spi_bits(8'h21, 8, r);
        spi_bits(8'hA5, 4, r);
        cs_high();
        check("abort no strobe", strobe_cnt, n);
        m_strobes = strobe_cnt;
        burst(8'h0B, 8'h21, 1, 32'h0, rxd, expd);
        check("abort not stored", rxd[31:24], 8'h00);

        // ---- randomized bursts vs model ----
        last_a = mon_addr; last_d = mon_data;
        for (int k = 0; k < 40; k++) begin
            int sel;
            logic [31:0] txd;
            if ($urandom_range(0, 2) == 0) begin
                pulse_sample(8'($urandom), 8'($urandom), 8'($urandom));
                repeat (3) @(negedge clk);
            end
            sel = $urandom_range(0, 9);
            if (sel < 5)      cmd = 8'h0B;
            else if (sel < 8) cmd = 8'h0A;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h00;
            end
            if ($urandom_range(0, 1) == 1) addr = 8'h20 + 8'($urandom_range(0, 14));
            else                            addr = 8'($urandom_range(0, 63));
            if (sel < 5 && $urandom_range(0, 2) == 0) addr = 8'h08;
            n   = $urandom_range(1, 4);
            txd = $urandom;
            if (cmd == 8'h0A) begin
                last_a = 6'(addr[5:0] + 6'(n - 1));
                last_d = txd[31-8*(n-1) -: 8];
            end
            burst(cmd, addr, n, txd, rxd, expd);
            for (int i = 0; i < n; i++)
                check($sformatf("rand%0d cmd%0h a%0h byte%0d", k, cmd, addr, i),
                      rxd[31-8*i -: 8], expd[31-8*i -: 8]);
            check($sformatf("rand%0d strobes", k), strobe_cnt, m_strobes);
            check($sformatf("rand%0d power_ctl", k), power_ctl, m_scr[6'h2D]);
            if (cmd == 8'h0A) begin
                check($sformatf("rand%0d wr_addr", k), mon_addr, last_a);
                check($sformatf("rand%0d wr_data", k), mon_data, last_d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
